seq_arith_8b_fxp_udiv: RTL and testbench

Iterative unsigned fixed-point divider for 8-bit Q4.4 operands (4 integer bits, 4 fractional bits). It is the inverse of the team's 8-bit Q4.4 unsigned fixed-point multiplier: it computes in0 / in1 in the same format, with the same overflow semantics. It retires one quotient bit per cycle behind latency-insensitive val/rdy interfaces, so it can sit in arithmetic pipelines that already consume multiplier results.

---
 rtl/seq_arith_8b_fxp_udiv.sv | 128 ++++++++++++
 tb/tb_seq_arith_8b_fxp_udiv.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/seq_arith_8b_fxp_udiv.sv
// Iterative unsigned Q4.4 divider, one quotient bit per cycle, val/rdy handshakes.
// Define SEQ_ARITH_8B_FXP_UDIV_ROUND_EN for round-half-up with one extra quotient bit.
module seq_arith_8b_fxp_udiv (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_val,
    output logic       in_rdy,
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    output logic       out_val,
    input  logic       out_rdy,
    output logic [7:0] out,
    output logic       overflow
);

`ifdef SEQ_ARITH_8B_FXP_UDIV_ROUND_EN
    localparam int NB = 13;
`else
    localparam int NB = 12;
`endif
    localparam logic [3:0] NITER = 4'(NB);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [7:0]    rem_q, rem_d;
    logic [7:0]    dvs_q, dvs_d;
    logic [NB-1:0] dq_q, dq_d;
    logic [7:0]    out_q, out_d;
    logic          ovf_q, ovf_d;

    // Dividend bits leave dq_q at the top while quotient bits enter at the bottom.
    logic [8:0]    trial;
    logic          ge;
    logic [NB-1:0] qn;
    logic [7:0]    res;
    logic          res_ovf;

    assign trial = {rem_q, dq_q[NB-1]};
    assign ge    = trial >= {1'b0, dvs_q};
    assign qn    = {dq_q[NB-2:0], ge};

`ifdef SEQ_ARITH_8B_FXP_UDIV_ROUND_EN
    logic [NB-1:0] rnd;
    // (q + 1) >> 1 without a wider adder: halve, then add back the dropped bit.
    assign rnd     = {1'b0, qn[NB-1:1]} + {{(NB-1){1'b0}}, qn[0]};
    assign res_ovf = |rnd[NB-1:8];
    assign res     = rnd[7:0];
`else
    assign res_ovf = |qn[NB-1:8];
    assign res     = qn[7:0];
`endif

    assign in_rdy   = (state_q == IDLE);
    assign out_val  = (state_q == DONE);
    assign out      = out_q;
    assign overflow = ovf_q;

    // Next-state: accept operands, iterate restoring division, hold result.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        dq_d    = dq_q;
        out_d   = out_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_val) begin
                    dvs_d = in1;
                    rem_d = 8'h00;
                    cnt_d = NITER;
                    dq_d  = {in0, {(NB-8){1'b0}}};
                    if (in1 == 8'h00) begin
                        state_d = DONE;
                        out_d   = 8'hFF;
                        ovf_d   = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                // When ge holds the true difference is below dvs_q, so 8 bits suffice.
                rem_d = ge ? (trial[7:0] - dvs_q) : trial[7:0];
                dq_d  = qn;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = DONE;
                    out_d   = res_ovf ? 8'hFF : res;
                    ovf_d   = res_ovf;
                end
            end
            DONE: begin
                if (out_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rem_q   <= 8'h00;
            dvs_q   <= 8'h00;
            dq_q    <= '0;
            out_q   <= 8'h00;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            dq_q    <= dq_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_seq_arith_8b_fxp_udiv.sv
// Bench for seq_arith_8b_fxp_udiv: directed plan cases plus random operands
// against an arithmetic reference model.
module tb_seq_arith_8b_fxp_udiv;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_val = 1'b0;
    logic       in_rdy;
    logic [7:0] in0 = 8'h00;
    logic [7:0] in1 = 8'h00;
    logic       out_val;
    logic       out_rdy = 1'b0;
    logic [7:0] out;
    logic       overflow;

    int checks = 0;
    int failures = 0;

    seq_arith_8b_fxp_udiv dut (
        .clk      (clk),
        .reset    (reset),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .in0      (in0),
        .in1      (in1),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out      (out),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: quotient of (in0 * 2^f) / in1 with plain integer math.
    task automatic model(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] q, output logic ov,
                         output int lat);
        int unsigned v;
        if (b == 8'h00) begin
            q = 8'hFF;
            ov = 1'b1;
            lat = 1;
        end else begin
`ifdef SEQ_ARITH_8B_FXP_UDIV_ROUND_EN
            v = ((int'(a) * 32) / int'(b) + 1) / 2;
            lat = 14;
`else
            v = (int'(a) * 16) / int'(b);
            lat = 13;
`endif
            ov = (v > 255);
            q = ov ? 8'hFF : v[7:0];
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input logic [7:0] a, input logic [7:0] b,
                       input int hold);
        logic [7:0] eq;
        logic       eo;
        int         el;
        int         k;
        model(a, b, eq, eo, el);
        chk("in_rdy_before", {31'd0, in_rdy}, 32'd1);
        in0 = a;
        in1 = b;
        in_val = 1'b1;
        step();
        in_val = 1'b0;
        in0 = 8'($urandom);
        in1 = 8'($urandom);
        k = 1;
        while (!out_val && k < 40) begin
            step();
            k++;
        end
        chk("latency", k, el);
        chk("out", {24'd0, out}, {24'd0, eq});
        chk("ovf", {31'd0, overflow}, {31'd0, eo});
        for (int i = 0; i < hold; i++) begin
            in_val = 1'b1;
            in0 = 8'($urandom);
            in1 = 8'($urandom);
            step();
            chk("hold_out", {24'd0, out}, {24'd0, eq});
            chk("hold_ovf", {31'd0, overflow}, {31'd0, eo});
            chk("hold_val", {31'd0, out_val}, 32'd1);
            chk("hold_rdy", {31'd0, in_rdy}, 32'd0);
        end
        in_val = 1'b0;
        out_rdy = 1'b1;
        step();
        out_rdy = 1'b0;
        chk("rdy_after", {31'd0, in_rdy}, 32'd1);
        chk("val_after", {31'd0, out_val}, 32'd0);
    endtask

    initial begin
        logic [7:0] ra, rb;
        #2;
        chk("rst_rdy", {31'd0, in_rdy}, 32'd1);
        chk("rst_val", {31'd0, out_val}, 32'd0);
        chk("rst_out", {24'd0, out}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        step();
        reset = 1'b1;
        step();

        txn(8'h20, 8'h10, 0);
        txn(8'h08, 8'h30, 0);
        txn(8'h10, 8'h04, 1);
        txn(8'h80, 8'h04, 0);
        txn(8'hF0, 8'h10, 0);
        txn(8'h35, 8'h00, 2);
        txn(8'h20, 8'h10, 5);
        txn(8'hFF, 8'h01, 0);
        txn(8'h01, 8'hFF, 0);

        // Reset in the middle of a computation.
        in0 = 8'h20;
        in1 = 8'h10;
        in_val = 1'b1;
        step();
        in_val = 1'b0;
        repeat (4) step();
        reset = 1'b0;
        #1;
        chk("mid_rdy", {31'd0, in_rdy}, 32'd1);
        chk("mid_val", {31'd0, out_val}, 32'd0);
        chk("mid_out", {24'd0, out}, 32'd0);
        chk("mid_ovf", {31'd0, overflow}, 32'd0);
        step();
        reset = 1'b1;
        step();
        txn(8'h20, 8'h10, 0);

        for (int n = 0; n < 40; n++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            txn(ra, rb, int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
